// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    WAIT_SPACE = 2'd2,
    DROP       = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;

  // Major opcode field consumed by the main control decoder.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INST_W-1:0] word);
    return word[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory request/ack bus, decode valid/ready bus and
// redirect input of the fetch stage. master = fetch unit, slave = memory/decode side.
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) ();

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INST_W-1:0]   imem_rdata;

  logic                inst_valid;
  logic                inst_ready;
  logic [INST_W-1:0]   inst;
  logic [ADDR_W-1:0]   inst_pc;
  logic [OPCODE_W-1:0] opcode;

  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, opcode,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, opcode,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small synchronous FIFO with registered storage (no bypass).
// Clear has priority over push and pop; push when full / pop when empty are ignored.
module ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop_i & (count_q != '0);
  assign push_ok = push_i & (count_q != (PW+1)'(DEPTH));

  // Storage, pointers and occupancy; storage is cleared on reset so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register, single-outstanding instruction fetch FSM and
// decode-side instruction buffer, with downstream redirect/flush.
// Optional macro IFETCH_PERF_EN adds saturating perf_fetched/perf_flushed counters.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  ifetch_if.master    bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned ENT_W = ADDR_W + INST_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              push;
  logic              pop;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ_after;
  logic [ENT_W-1:0]  head;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  // State, PC and the address of a request that became stale on redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Next state, PC update, FIFO push/pop; redirect overrides normal sequencing.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    push         = 1'b0;
    redirect_tgt = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    pop          = fifo_valid & bus.inst_ready & ~bus.redirect;
    occ_after    = {1'b0, fifo_count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

    if (bus.redirect) begin
      pc_d = redirect_tgt;
      // The in-flight request keeps its old address on the bus until it is acked.
      if (state_q == FETCH && !bus.imem_ack) begin
        state_d     = DROP;
        drop_addr_d = pc_q;
      end else if (state_q == DROP && !bus.imem_ack) begin
        state_d = DROP;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (bus.imem_ack) begin
            push    = 1'b1;
            pc_d    = pc_q + ADDR_W'(4);
            state_d = (occ_after < (CNT_W+1)'(FIFO_DEPTH)) ? FETCH : WAIT_SPACE;
          end
        end
        WAIT_SPACE: if (pop) state_d = FETCH;
        DROP:       if (bus.imem_ack) state_d = FETCH;
        default:    state_d = IDLE;
      endcase
    end
  end

  ifetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({pc_q, bus.imem_rdata}),
    .rdata_o (head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign bus.imem_req   = (state_q == FETCH) || (state_q == DROP);
  assign bus.imem_addr  = (state_q == DROP)  ? drop_addr_q :
                          (state_q == FETCH) ? pc_q : '0;
  assign bus.inst_valid = fifo_valid;
  assign bus.inst       = head[INST_W-1:0];
  assign bus.inst_pc    = head[ENT_W-1:INST_W];
  assign bus.opcode     = opcode_of(head[INST_W-1:0]);

`ifdef IFETCH_PERF_EN
  logic [31:0]      perf_fetched_q;
  logic [31:0]      perf_flushed_q;
  logic [32:0]      fetched_sum;
  logic [32:0]      flushed_sum;
  logic [CNT_W-1:0] flush_n;
  logic             drop_ack;

  // An ack is discarded either while draining a stale request or when it meets a redirect.
  always_comb begin
    drop_ack    = bus.imem_ack & ((state_q == DROP) | ((state_q == FETCH) & bus.redirect));
    flush_n     = bus.redirect ? fifo_count : '0;
    fetched_sum = {1'b0, perf_fetched_q} + 33'(pop);
    flushed_sum = {1'b0, perf_flushed_q} + 33'(flush_n) + 33'(drop_ack);
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      perf_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
